dsi_line_packetizer: RTL and testbench

Sits directly downstream of the 24-to-32-bit pixel packer. Consumes its 32-bit packed RGB888 word stream, where start/end of packet mark frame boundaries, and wraps it into MIPI DSI packets for the lane layer:
- one VSS short packet per frame;
- one Packed Pixel Stream RGB888 long packet (DI 0x3E) per line, with header ECC and payload CRC-16.

---
 rtl/dsi_line_packetizer.sv | 187 ++++++++++++++++++
 tb/tb_dsi_line_packetizer.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_line_packetizer.sv
// DSI line packetizer: wraps a packed RGB888 word stream into one VSS short
// packet per frame and one RGB888 long packet (DI 0x3E) per line, with
// header ECC and payload CRC-16. Payload words pass through with no latency.
module dsi_line_packetizer #(
  parameter int         LINE_BYTES = 2880,
  parameter logic [1:0] VC         = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_avl_st_data,
  input  logic        in_avl_st_valid,
  input  logic        in_avl_st_startofpacket,
  input  logic        in_avl_st_endofpacket,
  output logic        in_avl_st_ready,
  output logic [31:0] out_avl_st_data,
  output logic        out_avl_st_valid,
  output logic        out_avl_st_startofpacket,
  output logic        out_avl_st_endofpacket,
  output logic [1:0]  out_avl_st_empty,
  input  logic        out_avl_st_ready,
  output logic        status_line_err
);

  localparam int          WPL      = LINE_BYTES / 4;
  localparam logic [13:0] LAST_CNT = 14'(WPL - 1);
  localparam logic [15:0] WC       = 16'(LINE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_VSS, S_HDR, S_PAYLOAD, S_PAD, S_FOOTER
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [13:0] cnt_q, cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        line_err_q, line_err_d;
  // High until the frame's opening (sop) word has been consumed, so only a
  // later sop counts as a mid-frame restart.
  logic        first_q, first_d;

  logic [23:0] hdr;
  logic [7:0]  ecc;

  // Reflected CRC-16 (0x8408) over 32 bits, byte [7:0] first, LSB first.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                             input logic [31:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // DSI 6-bit Hamming ECC; each mask selects the header bits of one parity.
  function automatic logic [7:0] dsi_ecc(input logic [23:0] h);
    return {2'b00,
            ^(h & 24'hEFFC00), ^(h & 24'hDF03F0), ^(h & 24'hB8E38E),
            ^(h & 24'h749A6D), ^(h & 24'hF2555B), ^(h & 24'hF12CB7)};
  endfunction

  // Header fields depend only on the registered state and parameters.
  always_comb begin
    if (state_q == S_VSS) hdr = {16'h0000, VC, 6'h01};
    else                  hdr = {WC, VC, 6'h3E};
    ecc = dsi_ecc(hdr);
  end

  // Next-state, CRC/counter update and output decode; reset forces outputs low.
  always_comb begin
    state_d                  = state_q;
    crc_d                    = crc_q;
    cnt_d                    = cnt_q;
    frame_done_d             = frame_done_q;
    line_err_d               = line_err_q;
    first_d                  = first_q;
    in_avl_st_ready          = 1'b0;
    out_avl_st_data          = 32'h0;
    out_avl_st_valid         = 1'b0;
    out_avl_st_startofpacket = 1'b0;
    out_avl_st_endofpacket   = 1'b0;
    out_avl_st_empty         = 2'd0;

    case (state_q)
      S_IDLE: begin
        in_avl_st_ready = 1'b1;
        if (in_avl_st_valid && in_avl_st_startofpacket) begin
          // The sop word stays on the bus; it is consumed as the first payload word.
          in_avl_st_ready = 1'b0;
          first_d         = 1'b1;
          state_d         = S_VSS;
        end
      end
      S_VSS: begin
        out_avl_st_valid         = 1'b1;
        out_avl_st_data          = {ecc, hdr};
        out_avl_st_startofpacket = 1'b1;
        out_avl_st_endofpacket   = 1'b1;
        if (out_avl_st_ready) state_d = S_HDR;
      end
      S_HDR: begin
        out_avl_st_valid         = 1'b1;
        out_avl_st_data          = {ecc, hdr};
        out_avl_st_startofpacket = 1'b1;
        if (out_avl_st_ready) begin
          crc_d   = 16'hFFFF;
          cnt_d   = 14'd0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        out_avl_st_valid = in_avl_st_valid;
        out_avl_st_data  = in_avl_st_data;
        in_avl_st_ready  = out_avl_st_ready;
        if (in_avl_st_valid && out_avl_st_ready) begin
          crc_d   = crc16_word(crc_q, in_avl_st_data);
          cnt_d   = cnt_q + 14'd1;
          first_d = 1'b0;
          if (in_avl_st_startofpacket && !first_q) line_err_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            if (in_avl_st_endofpacket) frame_done_d = 1'b1;
            state_d = S_FOOTER;
          end else if (in_avl_st_endofpacket) begin
            line_err_d   = 1'b1;
            frame_done_d = 1'b1;
            state_d      = S_PAD;
          end
        end
      end
      S_PAD: begin
        out_avl_st_valid = 1'b1;
        if (out_avl_st_ready) begin
          crc_d = crc16_word(crc_q, 32'h0);
          cnt_d = cnt_q + 14'd1;
          if (cnt_q == LAST_CNT) state_d = S_FOOTER;
        end
      end
      S_FOOTER: begin
        out_avl_st_valid       = 1'b1;
        out_avl_st_data        = {16'h0000, crc_q};
        out_avl_st_endofpacket = 1'b1;
        out_avl_st_empty       = 2'd2;
        if (out_avl_st_ready) begin
          if (frame_done_q) begin
            frame_done_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            state_d = S_HDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      in_avl_st_ready          = 1'b0;
      out_avl_st_data          = 32'h0;
      out_avl_st_valid         = 1'b0;
      out_avl_st_startofpacket = 1'b0;
      out_avl_st_endofpacket   = 1'b0;
      out_avl_st_empty         = 2'd0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      crc_q        <= 16'hFFFF;
      cnt_q        <= 14'd0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      first_q      <= first_d;
    end
  end

  assign status_line_err = line_err_q;

endmodule

// File: tb/tb_dsi_line_packetizer.sv
// Testbench for dsi_line_packetizer: three instances (8-byte lines VC0,
// 16-byte lines VC2, 2880-byte lines VC0) checked against a scoreboard fed
// by an independent byte-wise CRC and column-table ECC model.
module tb_dsi_line_packetizer;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data   [NI];
  logic        in_valid  [NI];
  logic        in_sop    [NI];
  logic        in_eop    [NI];
  logic        in_ready  [NI];
  logic [31:0] out_data  [NI];
  logic        out_valid [NI];
  logic        out_sop   [NI];
  logic        out_eop   [NI];
  logic [1:0]  out_empty [NI];
  logic        out_ready [NI];
  logic        line_err  [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      dsi_line_packetizer #(
        .LINE_BYTES(gi == 0 ? 8 : (gi == 1 ? 16 : 2880)),
        .VC        (gi == 1 ? 2'd2 : 2'd0)
      ) u_dut (
        .clk                      (clk),
        .rst                      (rst),
        .in_avl_st_data           (in_data[gi]),
        .in_avl_st_valid          (in_valid[gi]),
        .in_avl_st_startofpacket  (in_sop[gi]),
        .in_avl_st_endofpacket    (in_eop[gi]),
        .in_avl_st_ready          (in_ready[gi]),
        .out_avl_st_data          (out_data[gi]),
        .out_avl_st_valid         (out_valid[gi]),
        .out_avl_st_startofpacket (out_sop[gi]),
        .out_avl_st_endofpacket   (out_eop[gi]),
        .out_avl_st_empty         (out_empty[gi]),
        .out_avl_st_ready         (out_ready[gi]),
        .status_line_err          (line_err[gi])
      );
    end
  endgenerate

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    bit          held;   // non-payload word: must hold under stall, in_ready low
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] frm[$];
  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;
  int          sel   = 0;
  bit          rand_ready = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [5:0] m_col(input int i);
    case (i)
      0:  return 6'h07;  1:  return 6'h0B;  2:  return 6'h0D;  3:  return 6'h0E;
      4:  return 6'h13;  5:  return 6'h15;  6:  return 6'h16;  7:  return 6'h19;
      8:  return 6'h1A;  9:  return 6'h1C;  10: return 6'h23;  11: return 6'h25;
      12: return 6'h26;  13: return 6'h29;  14: return 6'h2A;  15: return 6'h2C;
      16: return 6'h31;  17: return 6'h32;  18: return 6'h34;  19: return 6'h38;
      20: return 6'h1F;  21: return 6'h2F;  22: return 6'h37;  default: return 6'h3B;
    endcase
  endfunction

  function automatic logic [7:0] m_ecc(input logic [23:0] h);
    logic [5:0] s;
    s = 6'h0;
    for (int i = 0; i < 24; i++) if (h[i]) s = s ^ m_col(i);
    return {2'b00, s};
  endfunction

  function automatic logic [15:0] m_crc_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [7:0] x;
    x = b ^ crc[7:0];
    x = x ^ (x << 4);
    return {x, crc[15:8]} ^ {8'h00, (x >> 4)} ^ ({8'h00, x} << 3);
  endfunction

  function automatic logic [15:0] m_crc_word(input logic [15:0] crc, input logic [31:0] w);
    logic [15:0] c;
    c = crc;
    for (int b = 0; b < 4; b++) c = m_crc_byte(c, w[8*b +: 8]);
    return c;
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic s, input logic e,
                          input logic [1:0] emp, input bit h);
    exp_t x;
    x.data = d; x.sop = s; x.eop = e; x.empty = emp; x.held = h;
    exp_q.push_back(x);
  endtask

  // Expected DSI stream for the frame held in frm.
  task automatic push_frame(input int lb, input logic [1:0] vc);
    int          wpl;
    int          idx;
    logic [15:0] crc;
    logic [23:0] h;
    logic [31:0] w;
    bit          hd;
    wpl = lb / 4;
    idx = 0;
    h = {16'h0000, vc, 6'h01};
    push_exp({m_ecc(h), h}, 1'b1, 1'b1, 2'd0, 1'b1);
    while (idx < frm.size()) begin
      h = {16'(lb), vc, 6'h3E};
      push_exp({m_ecc(h), h}, 1'b1, 1'b0, 2'd0, 1'b1);
      crc = 16'hFFFF;
      for (int j = 0; j < wpl; j++) begin
        if (idx < frm.size()) begin w = frm[idx]; idx++; hd = 1'b0; end
        else begin w = 32'h0; hd = 1'b1; end
        crc = m_crc_word(crc, w);
        push_exp(w, 1'b0, 1'b0, 2'd0, hd);
      end
      push_exp({16'h0000, crc}, 1'b0, 1'b1, 2'd2, 1'b1);
    end
  endtask

  // ---------------- background processes ----------------
  task automatic ready_gen();
    for (int k = 0; k < NI; k++) out_ready[k] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++)
        out_ready[k] = (k == sel) ? (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
    end
  endtask

  task automatic monitor();
    exp_t        e;
    bit          stall_q;
    logic [31:0] h_data;
    logic        h_sop, h_eop;
    logic [1:0]  h_emp;
    stall_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          total++;
          if (out_valid[sel] !== 1'b1 || out_data[sel] !== h_data || out_sop[sel] !== h_sop ||
              out_eop[sel] !== h_eop || out_empty[sel] !== h_emp) begin
            bad++;
            $display("FAIL stall_hold inst=%0d: got v=%b data=%h, want v=1 data=%h", sel,
                     out_valid[sel], out_data[sel], h_data);
          end
        end
        stall_q = 1'b0;
        if (out_valid[sel] === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word inst=%0d: got data=%h, want no output", sel, out_data[sel]);
          end else begin
            e = exp_q[0];
            if (e.held) begin
              total++;
              if (in_ready[sel] !== 1'b0) begin
                bad++;
                $display("FAIL in_ready_nonpayload inst=%0d: got %b, want 0", sel, in_ready[sel]);
              end
            end
            if (out_ready[sel] === 1'b1) begin
              void'(exp_q.pop_front());
              total++;
              n_out++;
              if (out_data[sel] !== e.data || out_sop[sel] !== e.sop ||
                  out_eop[sel] !== e.eop || out_empty[sel] !== e.empty) begin
                bad++;
                $display("FAIL sb_word%0d inst=%0d: got data=%h sop=%b eop=%b empty=%0d, want data=%h sop=%b eop=%b empty=%0d",
                         n_out, sel, out_data[sel], out_sop[sel], out_eop[sel], out_empty[sel],
                         e.data, e.sop, e.eop, e.empty);
              end
              $display("word %0d inst=%0d data=%h sop=%b eop=%b empty=%0d", n_out, sel,
                       out_data[sel], out_sop[sel], out_eop[sel], out_empty[sel]);
            end else if (e.held) begin
              stall_q = 1'b1;
              h_data = out_data[sel]; h_sop = out_sop[sel];
              h_eop = out_eop[sel]; h_emp = out_empty[sel];
            end
          end
        end
      end
    end
  endtask

  // ---------------- stimulus helpers (enter and leave at posedge+1) ----------------
  task automatic send_word(input int k, input logic [31:0] d, input logic s,
                           input logic e, input bit gaps);
    int waited;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_data[k] = d; in_sop[k] = s; in_eop[k] = e; in_valid[k] = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready[k] === 1'b1) break;
      waited++;
      if (waited > 2000) begin
        total++; bad++;
        $display("FAIL accept_timeout inst=%0d: got no ready, want ready within 2000 cycles", k);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0; in_sop[k] = 1'b0; in_eop[k] = 1'b0;
  endtask

  task automatic send_frame(input int k, input bit gaps);
    for (int i = 0; i < frm.size(); i++)
      send_word(k, frm[i], i == 0, i == frm.size() - 1, gaps);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin @(negedge clk); n++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_%s: got %0d words outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b1; in_sop[k] = 1'b0; in_eop[k] = 1'b0; in_data[k] = 32'hDEADBEEF;
    end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      total++;
      if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 || out_data[k] !== 32'h0 ||
          out_sop[k] !== 1'b0 || out_eop[k] !== 1'b0 || out_empty[k] !== 2'd0 ||
          line_err[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d: got rdy=%b v=%b data=%h sop=%b eop=%b emp=%0d err=%b, want all 0",
                 k, in_ready[k], out_valid[k], out_data[k], out_sop[k], out_eop[k], out_empty[k], line_err[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) in_valid[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      total++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset inst=%0d: got rdy=%b v=%b, want rdy=1 v=0", k, in_ready[k], out_valid[k]);
      end
    end
    $display("reset done");
    @(posedge clk); #1;
  endtask

  task automatic test_crc_model();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) c = m_crc_byte(c, 8'(8'h31 + i));
    total++;
    if (c !== 16'h6F91) begin
      bad++;
      $display("FAIL crc_model_selftest: got %h, want 6f91", c);
    end
    $display("crc model self-test: %h", c);
  endtask

  task automatic test_discard();
    logic [31:0] pats [4];
    sel = 0;
    pats[0] = 32'h00000000; pats[1] = 32'hFFFFFFFF; pats[2] = 32'hA5A55A5A; pats[3] = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      in_data[0] = pats[i]; in_valid[0] = 1'b1; in_sop[0] = 1'b0; in_eop[0] = (i == 3);
      @(negedge clk);
      total++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
        bad++;
        $display("FAIL discard_%0d: got rdy=%b v=%b, want rdy=1 v=0", i, in_ready[0], out_valid[0]);
      end
      $display("discard word %0d data=%h rdy=%b", i, pats[i], in_ready[0]);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0; in_eop[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_two_lines();
    int n0, nexp;
    sel = 0; rand_ready = 1'b0;
    frm.delete();
    frm.push_back(32'h03020100); frm.push_back(32'h07060504);
    frm.push_back(32'h0B0A0908); frm.push_back(32'h0F0E0D0C);
    push_frame(8, 2'd0);
    total++;
    if (exp_q[0].data !== 32'h07000001) begin
      bad++;
      $display("FAIL vss_model: got %h, want 07000001", exp_q[0].data);
    end
    nexp = exp_q.size();
    n0 = n_out;
    send_frame(0, 1'b0);
    wait_drain("two_lines");
    total++;
    if (n_out - n0 !== nexp) begin
      bad++;
      $display("FAIL two_lines_count: got %0d words, want %0d", n_out - n0, nexp);
    end
    @(negedge clk);
    total++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || line_err[0] !== 1'b0) begin
      bad++;
      $display("FAIL two_lines_idle: got rdy=%b v=%b err=%b, want rdy=1 v=0 err=0",
               in_ready[0], out_valid[0], line_err[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_short_frame();
    sel = 1; rand_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (line_err[1] !== 1'b0) begin
      bad++;
      $display("FAIL short_err_before: got %b, want 0", line_err[1]);
    end
    frm.delete();
    frm.push_back(32'h44332211); frm.push_back(32'h88776655);
    push_frame(16, 2'd2);
    send_frame(1, 1'b0);
    wait_drain("short_frame");
    @(negedge clk);
    total++;
    if (line_err[1] !== 1'b1) begin
      bad++;
      $display("FAIL short_err_after: got %b, want 1", line_err[1]);
    end
    total++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
      bad++;
      $display("FAIL short_idle: got rdy=%b v=%b, want rdy=1 v=0", in_ready[1], out_valid[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    sel = 2; rand_ready = 1'b1;
    frm.delete();
    for (int i = 0; i < 3 * 720; i++) frm.push_back($urandom);
    push_frame(2880, 2'd0);
    send_frame(2, 1'b1);
    wait_drain("random");
    rand_ready = 1'b0;
    @(negedge clk);
    total++;
    if (line_err[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
      bad++;
      $display("FAIL random_end: got err=%b rdy=%b, want err=0 rdy=1", line_err[2], in_ready[2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    sel = 0; rand_ready = 1'b0;
    @(posedge clk); #1;
    frm.delete();
    frm.push_back(32'hCAFEF00D); frm.push_back(32'h0BADBEEF);
    frm.push_back(32'h11111111); frm.push_back(32'h22222222);
    push_frame(8, 2'd0);
    send_word(0, frm[0], 1'b1, 1'b0, 1'b0);
    in_data[0] = frm[1]; in_valid[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0 || out_data[0] !== 32'h0 ||
        out_sop[0] !== 1'b0 || out_eop[0] !== 1'b0 || out_empty[0] !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got rdy=%b v=%b data=%h sop=%b eop=%b emp=%0d, want all 0",
               in_ready[0], out_valid[0], out_data[0], out_sop[0], out_eop[0], out_empty[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid[0] = 1'b0;
    exp_q.delete();
    @(negedge clk);
    total++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_idle: got rdy=%b v=%b, want rdy=1 v=0", in_ready[0], out_valid[0]);
    end
    @(posedge clk); #1;
    push_frame(8, 2'd0);
    send_frame(0, 1'b0);
    wait_drain("after_reset");
    @(negedge clk);
    total++;
    if (line_err[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL after_reset_end: got err=%b rdy=%b, want err=0 rdy=1", line_err[0], in_ready[0]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; in_sop[k] = 1'b0; in_eop[k] = 1'b0; in_data[k] = 32'h0;
    end
    fork
      monitor();
      ready_gen();
    join_none
    test_reset();
    test_crc_model();
    test_discard();
    test_two_lines();
    test_short_frame();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
